mist_video_syncout: RTL

//  Final video output stage placed after the OSD/blend stages, before the VGA pins.

---
 rtl/mist_video_syncout_if.sv | 34 +++
 rtl/mist_video_syncout.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mist_video_syncout_if.sv
// Video bus between the blend stages and the VGA output stage: raw core video in, pin-ready video out.
// Flow control: no valid/ready pair; ce_pix is the only qualifier, and a pixel is taken on each clk_sys edge where ce_pix=1.
interface mist_video_syncout_if #(
    parameter int COLOR_DEPTH = 6,
    parameter int OUT_DEPTH   = 6
) ();
    logic                   ce_pix;
    logic [1:0]             mode;
    logic [COLOR_DEPTH-1:0] R;
    logic [COLOR_DEPTH-1:0] G;
    logic [COLOR_DEPTH-1:0] B;
    logic                   HBlank;
    logic                   VBlank;
    logic                   HSync;
    logic                   VSync;
    logic [OUT_DEPTH-1:0]   VGA_R;
    logic [OUT_DEPTH-1:0]   VGA_G;
    logic [OUT_DEPTH-1:0]   VGA_B;
    logic                   VGA_HS;
    logic                   VGA_VS;
    logic                   h_pol;
    logic                   v_pol;
    logic                   sync_valid;

    modport master (
        output ce_pix, mode, R, G, B, HBlank, VBlank, HSync, VSync,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, h_pol, v_pol, sync_valid
    );

    modport slave (
        input  ce_pix, mode, R, G, B, HBlank, VBlank, HSync, VSync,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, h_pol, v_pol, sync_valid
    );
endinterface

// File: rtl/mist_video_syncout.sv
// VGA output stage: depth conversion, blanking, aligned delay pipe, sync polarity
// auto-detection and normalisation to active-low separate or composite sync.
module mist_video_syncout_pol_det #(
    parameter int CNT_W = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic rise,
    input  logic fall,
    input  logic inc,
    output logic pol,
    output logic done
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] hi_cnt, lo_cnt, hi_len, lo_len;
    logic             armed, got_hi, got_lo;

    // The first edge after reset only arms the detector, so a phase cut short by reset is never judged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
            hi_len <= '0;
            lo_len <= '0;
            armed  <= 1'b0;
            got_hi <= 1'b0;
            got_lo <= 1'b0;
            pol    <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (inc && level && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
            if (inc && !level && lo_cnt != CNT_MAX) lo_cnt <= lo_cnt + 1'b1;
            if (got_hi && got_lo) begin
                if (lo_len != hi_len) pol <= (lo_len > hi_len);
                done   <= 1'b1;
                got_hi <= 1'b0;
                got_lo <= 1'b0;
            end
            if (fall) begin
                hi_len <= hi_cnt;
                hi_cnt <= '0;
                got_hi <= armed;
                armed  <= 1'b1;
            end
            if (rise) begin
                lo_len <= lo_cnt;
                lo_cnt <= '0;
                got_lo <= armed;
                armed  <= 1'b1;
            end
        end
    end
endmodule

module mist_video_syncout #(
    parameter int COLOR_DEPTH = 6,
    parameter int OUT_DEPTH   = 6,
    parameter int DELAY       = 1,
    parameter int HCNT_W      = 12,
    parameter int VCNT_W      = 10,
    parameter int USE_BLANKS  = 0
) (
    input logic                  clk_sys,
    input logic                  reset_n,
    mist_video_syncout_if.slave  vid
);
    typedef struct packed {
        logic [OUT_DEPTH-1:0] r;
        logic [OUT_DEPTH-1:0] g;
        logic [OUT_DEPTH-1:0] b;
        logic                 hs;
        logic                 vs;
    } pix_t;

    function automatic logic [OUT_DEPTH-1:0] expand(input logic [COLOR_DEPTH-1:0] c);
        logic [COLOR_DEPTH*OUT_DEPTH-1:0] rep;
        rep = {OUT_DEPTH{c}};
        return rep[COLOR_DEPTH*OUT_DEPTH-1 -: OUT_DEPTH];
    endfunction

    logic primed, hs_prev, vs_prev;
    logic h_rise, h_fall, v_rise, v_fall;
    logic h_pol, v_pol, h_done, v_done, sync_valid_q;

    // primed masks the first cycle after reset so a sync already asserted is not seen as an edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed       <= 1'b0;
            hs_prev      <= 1'b0;
            vs_prev      <= 1'b0;
            sync_valid_q <= 1'b0;
        end else begin
            primed       <= 1'b1;
            hs_prev      <= vid.HSync;
            vs_prev      <= vid.VSync;
            sync_valid_q <= h_done & v_done;
        end
    end

    assign h_rise = primed &  vid.HSync & ~hs_prev;
    assign h_fall = primed & ~vid.HSync &  hs_prev;
    assign v_rise = primed &  vid.VSync & ~vs_prev;
    assign v_fall = primed & ~vid.VSync &  vs_prev;

    mist_video_syncout_pol_det #(.CNT_W(HCNT_W)) u_hdet (
        .clk(clk_sys), .rst_n(reset_n), .level(vid.HSync), .rise(h_rise), .fall(h_fall),
        .inc(1'b1), .pol(h_pol), .done(h_done)
    );

    // Vertical phases are measured in lines, counted by raw HSync rising edges.
    mist_video_syncout_pol_det #(.CNT_W(VCNT_W)) u_vdet (
        .clk(clk_sys), .rst_n(reset_n), .level(vid.VSync), .rise(v_rise), .fall(v_fall),
        .inc(h_rise), .pol(v_pol), .done(v_done)
    );

    pix_t pix_in, last;
    logic blank;

    always_comb begin
        blank     = (USE_BLANKS != 0) && (vid.HBlank || vid.VBlank);
        pix_in.r  = blank ? '0 : expand(vid.R);
        pix_in.g  = blank ? '0 : expand(vid.G);
        pix_in.b  = blank ? '0 : expand(vid.B);
        pix_in.hs = vid.HSync ^ ~h_pol;
        pix_in.vs = vid.VSync ^ ~v_pol;
    end

    generate
        if (DELAY == 0) begin : g_no_delay
            assign last = pix_in;
        end else begin : g_delay
            pix_t pipe_q [DELAY];
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
                end else if (vid.ce_pix) begin
                    pipe_q[0] <= pix_in;
                    for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign last = pipe_q[DELAY-1];
        end
    endgenerate

    logic [OUT_DEPTH-1:0] r_q, g_q, b_q;
    logic                 hs_q, vs_q, csync;

    assign csync = last.hs | last.vs;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else if (vid.ce_pix) begin
            r_q <= last.r;
            g_q <= last.g;
            b_q <= last.b;
            case (vid.mode)
                2'd1: begin
                    hs_q <= ~csync;
                    vs_q <= 1'b1;
                end
                2'd2: begin
                    hs_q <= ~csync;
                    vs_q <= ~csync;
                end
                default: begin
                    hs_q <= ~last.hs;
                    vs_q <= ~last.vs;
                end
            endcase
        end
    end

    assign vid.VGA_R      = r_q;
    assign vid.VGA_G      = g_q;
    assign vid.VGA_B      = b_q;
    assign vid.VGA_HS     = hs_q;
    assign vid.VGA_VS     = vs_q;
    assign vid.h_pol      = h_pol;
    assign vid.v_pol      = v_pol;
    assign vid.sync_valid = sync_valid_q;
endmodule
